// File: rtl/mod_n_counter_prog.sv
// Runtime-programmable up/down modulo counter with wrap, saturate and one-shot end modes.
// Optional prescaler is compiled in when MOD_N_PRESCALE_EN is defined.
module mod_n_counter_prog #(
    parameter int WIDTH       = 3,
    parameter int DEFAULT_MAX = 5,
    parameter int PRESCALE    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_max,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_wrap,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       MODE_SAT  = 2'b01;
    localparam logic [1:0]       MODE_ONE  = 2'b10;
    localparam logic [WIDTH-1:0] MAX_RST   = WIDTH'(DEFAULT_MAX);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, done_q;

    // A step attempt happens on every enabled RUN cycle and on the PAUSE->RUN edge.
    logic step_try;
    logic step_ok;
    logic at_end;

    assign step_try = i_en && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
    assign at_end   = i_up_down ? (count_q >= max_q) : (count_q == '0);

`ifdef MOD_N_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q, psc_d;

    assign step_ok = (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q;
        if (i_load) begin
            psc_d = '0;
        end else if (step_try) begin
            psc_d = step_ok ? '0 : psc_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    // No prescaler: every attempt is a real step (PRESCALE must still be legal).
    assign step_ok = (PRESCALE >= 1);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        wrap_d  = 1'b0;

        if (i_load) begin
            max_d   = i_max;
            count_d = (i_load_val > i_max) ? i_max : i_load_val;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (i_en) state_d = ST_RUN;
                ST_RUN:   if (!i_en) state_d = ST_PAUSE;
                ST_PAUSE: if (i_en) state_d = ST_RUN;
                default:  state_d = ST_DONE;
            endcase

            if (step_try && step_ok) begin
                if (!at_end) begin
                    count_d = i_up_down ? count_q + ONE : count_q - ONE;
                end else if (i_mode == MODE_SAT) begin
                    count_d = count_q;
                end else if (i_mode == MODE_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    // Wrap and the reserved mode both wrap to the opposite end.
                    count_d = i_up_down ? '0 : max_q;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            max_q   <= MAX_RST;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign o_Q     = count_q;
    assign o_wrap  = wrap_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_mod_n_counter_prog.sv
// Directed bench for mod_n_counter_prog (WIDTH=3, DEFAULT_MAX=5, prescaler disabled).
module tb_mod_n_counter_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_down;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] max_v;
    logic [1:0] mode;
    logic [2:0] q;
    logic       wrap;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int checks;
    int failures;

    mod_n_counter_prog #(.WIDTH(3), .DEFAULT_MAX(5), .PRESCALE(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_up_down  (up_down),
        .i_load     (load),
        .i_load_val (load_val),
        .i_max      (max_v),
        .i_mode     (mode),
        .o_Q        (q),
        .o_wrap     (wrap),
        .o_busy     (busy),
        .o_done     (done),
        .o_state    (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        max_v    = '0;
        mode     = 2'b00;
        up_down  = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] val, input logic [2:0] mx, input logic [1:0] md,
                           input logic en_v);
        load     = 1'b1;
        load_val = val;
        max_v    = mx;
        mode     = md;
        en       = en_v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [2:0] up_seq[7];
        logic [2:0] sat_exp;
        checks   = 0;
        failures = 0;
        up_seq   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

        // reset state
        do_reset();
        check("rst_q", q, 0);
        check("rst_wrap", wrap, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);

        // 1: up, wrap mode
        en = 1'b1;
        tick();
        check("t1_enter_q", q, 0);
        check("t1_enter_busy", busy, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t1_q", q, up_seq[i]);
            check("t1_wrap", wrap, (i == 5) ? 1 : 0);
            check("t1_busy", busy, 1);
        end

        // 2: down, wrap mode, pause and resume
        do_reset();
        up_down = 1'b0;
        en      = 1'b1;
        tick();
        check("t2_enter_q", q, 0);
        tick();
        check("t2_q5", q, 5);
        check("t2_wrap5", wrap, 1);
        tick();
        check("t2_q4", q, 4);
        check("t2_wrap4", wrap, 0);
        tick();
        check("t2_q3", q, 3);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_q", q, 3);
            check("t2_hold_busy", busy, 1);
        end
        check("t2_pause_state", state, 2);
        en = 1'b1;
        tick();
        check("t2_resume_q", q, 2);

        // 3: saturate up
        do_reset();
        mode = 2'b01;
        en   = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            sat_exp = (i > 5) ? 3'd5 : 3'(i);
            check("t3_q", q, sat_exp);
            check("t3_wrap", wrap, 0);
            check("t3_done", done, 0);
        end

        // 4: one-shot with loaded modulus
        do_load(3'd0, 3'd2, 2'b10, 1'b1);
        check("t4_load_q", q, 0);
        check("t4_load_busy", busy, 0);
        tick();
        check("t4_run_q", q, 0);
        tick();
        check("t4_q1", q, 1);
        tick();
        check("t4_q2", q, 2);
        check("t4_q2_done", done, 0);
        tick();
        check("t4_done", done, 1);
        check("t4_done_busy", busy, 0);
        check("t4_done_q", q, 2);
        en   = 1'b0;
        mode = 2'b00;
        tick();
        en = 1'b1;
        tick();
        tick();
        check("t4_ignore_q", q, 2);
        check("t4_ignore_done", done, 1);
        do_load(3'd1, 3'd2, 2'b10, 1'b0);
        check("t4_reload_q", q, 1);
        check("t4_reload_done", done, 0);

        // 5: load clamps and suppresses the step
        do_load(3'd7, 3'd4, 2'b00, 1'b1);
        check("t5_clamp_q", q, 4);
        check("t5_idle_state", state, 0);
        check("t5_idle_busy", busy, 0);
        tick();
        check("t5_run_busy", busy, 1);
        check("t5_run_q", q, 4);
        tick();
        check("t5_wrap_q", q, 0);
        check("t5_wrap", wrap, 1);

        // r_max == 0 corner: wrap on every step, one-shot on first step
        do_load(3'd3, 3'd0, 2'b00, 1'b1);
        check("z_load_q", q, 0);
        tick();
        tick();
        check("z_wrap1", wrap, 1);
        tick();
        check("z_wrap2", wrap, 1);
        check("z_q", q, 0);
        do_load(3'd0, 3'd0, 2'b10, 1'b1);
        tick();
        check("z_os_run", done, 0);
        tick();
        check("z_os_done", done, 1);

        // 6: reset beats load mid-run, r_max returns to default
        do_reset();
        en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("t6_pre_q", q, 3);
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 3'd2;
        max_v    = 3'd7;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        check("t6_rst_q", q, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_wrap", wrap, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t6_q", q, i);
        end
        tick();
        check("t6_wrap_q", q, 0);
        check("t6_wrap", wrap, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
